// File: rtl/dm_bus_pkg.sv
// Shared types for the data-memory bus bridge: FSM states, access sizes, funct3 decode.
// Reuses the core's F3_TYPE_* defines when present, otherwise supplies the RV32 encodings.
`ifndef F3_TYPE_B
`define F3_TYPE_B  3'b000
`endif
`ifndef F3_TYPE_H
`define F3_TYPE_H  3'b001
`endif
`ifndef F3_TYPE_W
`define F3_TYPE_W  3'b010
`endif
`ifndef F3_TYPE_BU
`define F3_TYPE_BU 3'b100
`endif
`ifndef F3_TYPE_HU
`define F3_TYPE_HU 3'b101
`endif

package dm_bus_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unused funct3 encodings fall back to word so they trip the alignment check.
  function automatic size_t f3_to_size(input logic [2:0] f3);
    case (f3)
      `F3_TYPE_B, `F3_TYPE_BU: return SZ_BYTE;
      `F3_TYPE_H, `F3_TYPE_HU: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for one access: write strobes, lane-shifted store data,
// misalignment flag and the right-shift amount applied to returning read words.
module dm_lane_align
  import dm_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_off,
  input  size_t             i_size,
  input  logic [DATA_W-1:0] i_wd,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_misaligned,
  output logic [4:0]        o_rshift
);

  logic [DATA_W-1:0] w_wd_masked;

  always_comb begin
    o_rshift     = {i_off, 3'b000};
    o_wstrb      = {STRB_W{1'b1}};
    w_wd_masked  = i_wd;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_wstrb     = 4'b0001 << i_off;
        w_wd_masked = {{(DATA_W-8){1'b0}}, i_wd[7:0]};
      end
      SZ_HALF: begin
        o_wstrb      = i_off[1] ? 4'b1100 : 4'b0011;
        w_wd_masked  = {{(DATA_W-16){1'b0}}, i_wd[15:0]};
        o_misaligned = i_off[0];
      end
      default: begin
        o_misaligned = |i_off;
      end
    endcase
    o_wdata = w_wd_masked << o_rshift;
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// Turns each core load/store into one valid/ready bus request plus response, stalling the core
// until it retires. Define DM_TIMEOUT_EN to add a watchdog of TIMEOUT_CYCLES per wait state.
module dm_bus_bridge
  import dm_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_DM_addr,
  input  logic [DATA_W-1:0] i_DM_wd,
  input  logic              i_DM_wen,
  input  logic              i_DM_ren,
  input  logic [2:0]        i_DM_funct3,
  output logic [DATA_W-1:0] o_DM_rd,
  output logic              o_stall,
  output logic              o_misaligned,
  output logic              o_bus_err,
  output logic              o_BUS_valid,
  input  logic              i_BUS_ready,
  output logic [ADDR_W-1:0] o_BUS_addr,
  output logic              o_BUS_we,
  output logic [DATA_W-1:0] o_BUS_wdata,
  output logic [STRB_W-1:0] o_BUS_wstrb,
  input  logic              i_BUS_rvalid,
  input  logic [DATA_W-1:0] i_BUS_rdata,
  input  logic              i_BUS_err
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_we;
  logic [4:0]          r_rshift;
  logic [DATA_W-1:0]   r_rd;
  logic                r_err;

  logic                w_req;
  logic                w_mis;
  logic                w_accept;
  logic                w_tmo;
  size_t               w_size;
  logic [STRB_W-1:0]   w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata_sh;
  logic [4:0]          w_rshift;

  assign w_req      = i_DM_wen | i_DM_ren;
  assign w_size     = f3_to_size(i_DM_funct3);
  assign w_accept   = (r_state == IDLE) && w_req && !w_mis;
  assign w_rdata_sh = i_BUS_rdata >> r_rshift;

  dm_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_off        (i_DM_addr[1:0]),
    .i_size       (w_size),
    .i_wd         (i_DM_wd),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis),
    .o_rshift     (w_rshift)
  );

`ifdef DM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Restarts on entry to REQ and to RESP so each wait state gets the full budget.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (w_accept || (r_state == REQ && i_BUS_ready)) begin
      r_tmo_cnt <= '0;
    end else if (r_state == REQ || r_state == RESP) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_we     <= 1'b0;
      r_rshift <= '0;
      r_rd     <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= {i_DM_addr[ADDR_W-1:2], 2'b00};
            r_wdata  <= w_wdata;
            r_wstrb  <= w_wstrb;
            r_we     <= i_DM_wen;
            r_rshift <= w_rshift;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (i_BUS_ready) begin
            if (i_BUS_rvalid) begin
              r_err   <= i_BUS_err;
              if (i_BUS_err) r_rd <= '0;
              else if (!r_we) r_rd <= w_rdata_sh;
              r_state <= DONE;
            end else begin
              r_state <= RESP;
            end
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rd    <= '0;
            r_state <= DONE;
          end
        end
        RESP: begin
          if (i_BUS_rvalid) begin
            r_err   <= i_BUS_err;
            if (i_BUS_err) r_rd <= '0;
            else if (!r_we) r_rd <= w_rdata_sh;
            r_state <= DONE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rd    <= '0;
            r_state <= DONE;
          end
        end
        default: begin
          // The request visible here is the retiring one; never re-accept it.
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_stall      = !i_rst && ((r_state == REQ) || (r_state == RESP) || w_accept);
  assign o_misaligned = !i_rst && (r_state == IDLE) && w_req && w_mis;
  assign o_bus_err    = (r_state == DONE) && r_err;
  assign o_DM_rd      = r_rd;
  assign o_BUS_valid  = (r_state == REQ);
  assign o_BUS_addr   = r_addr;
  assign o_BUS_we     = r_we;
  assign o_BUS_wdata  = r_wdata;
  assign o_BUS_wstrb  = r_wstrb;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Scoreboard bench for dm_bus_bridge: expected bus requests and retirements are queued at
// drive time and compared when the bridge issues the request and when the access retires.
`timescale 1ns/1ps
module tb_dm_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr, dm_wd, dm_rd, bus_addr, bus_wdata, bus_rdata;
  logic        dm_wen, dm_ren, stall, misaligned, bus_err;
  logic [2:0]  dm_f3;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid, bus_errin;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  dm_bus_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_DM_addr    (dm_addr),
    .i_DM_wd      (dm_wd),
    .i_DM_wen     (dm_wen),
    .i_DM_ren     (dm_ren),
    .i_DM_funct3  (dm_f3),
    .o_DM_rd      (dm_rd),
    .o_stall      (stall),
    .o_misaligned (misaligned),
    .o_bus_err    (bus_err),
    .o_BUS_valid  (bus_valid),
    .i_BUS_ready  (bus_ready),
    .o_BUS_addr   (bus_addr),
    .o_BUS_we     (bus_we),
    .o_BUS_wdata  (bus_wdata),
    .o_BUS_wstrb  (bus_wstrb),
    .i_BUS_rvalid (bus_rvalid),
    .i_BUS_rdata  (bus_rdata),
    .i_BUS_err    (bus_errin)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [31:0] stalls;
  } rsp_exp_t;

  bus_exp_t    q_req[$];
  rsp_exp_t    q_rsp[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_rd_hold = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic mis_of(input logic [31:0] a, input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] strb_of(input logic [31:0] a, input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 4'b0001 << a[1:0];
    if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] wd, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] m;
    if (f3[1:0] == 2'b00) m = wd & 32'h0000_00FF;
    else if (f3[1:0] == 2'b01) m = wd & 32'h0000_FFFF;
    else m = wd;
    return m << (8 * a[1:0]);
  endfunction

  task automatic clear_core();
    dm_wen = 1'b0; dm_ren = 1'b0; dm_addr = 32'h0; dm_wd = 32'h0; dm_f3 = 3'b010;
  endtask

  task automatic access(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic wen, input logic ren, input logic [2:0] f3,
                        input int rdy_dly, input int rsp_dly,
                        input logic [31:0] mem, input logic berr);
    bus_exp_t be, bo;
    rsp_exp_t re, ro;
    int stalls;
    step();
    dm_addr = a; dm_wd = wd; dm_wen = wen; dm_ren = ren; dm_f3 = f3;
    if (mis_of(a, f3)) begin
      #1;
      check_val({name, ".misaligned"}, 32'(misaligned), 32'd1);
      check_val({name, ".mis_stall"},  32'(stall),      32'd0);
      check_val({name, ".mis_valid"},  32'(bus_valid),  32'd0);
      step();
      clear_core();
      #1;
      check_val({name, ".mis_pulse_end"}, 32'(misaligned), 32'd0);
      check_val({name, ".mis_no_req"},    32'(bus_valid),  32'd0);
      $display("txn %s: addr=0x%08h rejected as misaligned", name, a);
      return;
    end
    be.addr  = a & ~32'd3;
    be.we    = wen;
    be.wdata = wen ? wdata_of(wd, a, f3) : 32'h0;
    be.wstrb = strb_of(a, f3);
    q_req.push_back(be);
    if (berr) exp_rd_hold = 32'h0;
    else if (!wen) exp_rd_hold = mem >> (8 * a[1:0]);
    re.rd     = exp_rd_hold;
    re.err    = berr;
    re.stalls = 32'(2 + rdy_dly + rsp_dly);
    q_rsp.push_back(re);
    #1;
    stalls = stall ? 1 : 0;
    step();
    bo = q_req.pop_front();
    for (int i = 0; i <= rdy_dly; i++) begin
      check_val({name, ".valid"}, 32'(bus_valid), 32'd1);
      check_val({name, ".addr"},  bus_addr,       bo.addr);
      check_val({name, ".we"},    32'(bus_we),    32'(bo.we));
      check_val({name, ".wstrb"}, 32'(bus_wstrb), 32'(bo.wstrb));
      if (bo.we) check_val({name, ".wdata"}, bus_wdata, bo.wdata);
      if (stall) stalls++;
      if (i == rdy_dly) begin
        bus_ready = 1'b1;
        if (rsp_dly == 0) begin
          bus_rvalid = 1'b1; bus_rdata = mem; bus_errin = berr;
        end
      end
      step();
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_errin = 1'b0;
    end
    for (int i = 1; i <= rsp_dly; i++) begin
      if (stall) stalls++;
      if (i == rsp_dly) begin
        bus_rvalid = 1'b1; bus_rdata = mem; bus_errin = berr;
      end
      step();
      bus_rvalid = 1'b0; bus_errin = 1'b0;
    end
    ro = q_rsp.pop_front();
    check_val({name, ".done_stall"}, 32'(stall),   32'd0);
    check_val({name, ".stall_cyc"},  32'(stalls),  ro.stalls);
    check_val({name, ".rd"},         dm_rd,        ro.rd);
    check_val({name, ".bus_err"},    32'(bus_err), 32'(ro.err));
    check_val({name, ".done_valid"}, 32'(bus_valid), 32'd0);
    step();
    clear_core();
    #1;
    check_val({name, ".err_pulse_end"}, 32'(bus_err), 32'd0);
    check_val({name, ".rd_hold"},       dm_rd,        ro.rd);
    $display("txn %s: addr=0x%08h we=%0d rd=0x%08h err=%0d stalls=%0d",
             name, a, wen, dm_rd, bus_err, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqc;
    rst = 1'b1;
    clear_core();
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_errin = 1'b0;
    #1;
    check_val("rst.stall",  32'(stall),      32'd0);
    check_val("rst.valid",  32'(bus_valid),  32'd0);
    check_val("rst.rd",     dm_rd,           32'd0);
    check_val("rst.buserr", 32'(bus_err),    32'd0);
    check_val("rst.mis",    32'(misaligned), 32'd0);
    check_val("rst.addr",   bus_addr,        32'd0);
    check_val("rst.wstrb",  32'(bus_wstrb),  32'd0);
    step(); step();
    rst = 1'b0;

    access("sw_word",   32'h100, 32'hDEADBEEF, 1, 0, 3'b010, 0, 1, 32'h0, 0);
    access("lb_byte",   32'h203, 32'h0,        0, 1, 3'b000, 0, 1, 32'hAABBCCDD, 0);
    access("sh_half",   32'h102, 32'h00001234, 1, 0, 3'b001, 0, 1, 32'h0, 0);
    access("lw_mis",    32'h101, 32'h0,        0, 1, 3'b010, 0, 0, 32'h0, 0);
    access("lw_err",    32'h204, 32'h0,        0, 1, 3'b010, 5, 1, 32'h55555555, 1);
    access("lw_fast",   32'h208, 32'h0,        0, 1, 3'b010, 0, 0, 32'hCAFEF00D, 0);
    access("lhu_hi",    32'h20A, 32'h0,        0, 1, 3'b101, 1, 2, 32'h89ABCDEF, 0);
    access("sb_wr_rd",  32'h301, 32'h123456A5, 1, 1, 3'b000, 2, 0, 32'h0, 0);
    access("sh_mis",    32'h103, 32'h0000BEEF, 1, 0, 3'b001, 0, 0, 32'h0, 0);
    access("sbu_lane0", 32'h304, 32'hFFFFFF7E, 1, 0, 3'b100, 0, 1, 32'h0, 0);

    // Stray response while idle must not disturb the retired load data.
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000; bus_errin = 1'b1;
    #1;
    check_val("idle_rv.stall", 32'(stall), 32'd0);
    step();
    bus_rvalid = 1'b0; bus_errin = 1'b0;
    check_val("idle_rv.rd",     dm_rd,        exp_rd_hold);
    check_val("idle_rv.buserr", 32'(bus_err), 32'd0);
    $display("txn idle_rvalid: rd=0x%08h", dm_rd);

    // Reset while waiting for the response of an accepted load.
    step();
    dm_addr = 32'h3F0; dm_ren = 1'b1; dm_f3 = 3'b010;
    step();
    check_val("rst_mid.valid_req", 32'(bus_valid), 32'd1);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    check_val("rst_mid.resp_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_rd_hold = 32'h0;
    check_val("rst_mid.stall", 32'(stall),     32'd0);
    check_val("rst_mid.valid", 32'(bus_valid), 32'd0);
    check_val("rst_mid.rd",    dm_rd,          exp_rd_hold);
    clear_core();
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    step();
    bus_rvalid = 1'b0;
    check_val("rst_mid.late_rd",    dm_rd,        exp_rd_hold);
    check_val("rst_mid.late_stall", 32'(stall),   32'd0);
    check_val("rst_mid.late_err",   32'(bus_err), 32'd0);
    $display("txn reset_in_resp: rd=0x%08h", dm_rd);

`ifdef DM_TIMEOUT_EN
    step();
    dm_addr = 32'h400; dm_ren = 1'b1; dm_f3 = 3'b010;
    step();
    reqc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      if (bus_valid) reqc++;
      step();
    end
    exp_rd_hold = 32'h0;
    check_val("tmo.req_cycles", 32'(reqc),    32'd8);
    check_val("tmo.stall",      32'(stall),   32'd0);
    check_val("tmo.bus_err",    32'(bus_err), 32'd1);
    check_val("tmo.rd",         dm_rd,        exp_rd_hold);
    clear_core();
    $display("txn timeout: req_cycles=%0d err=%0d", reqc, bus_err);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
